// File: rtl/pipe_control_unit_if.sv
// Decoder-to-datapath bundle for the pipelined control unit.
// Master drives D-stage fields and the zero flag; slave returns controls.
interface pipe_control_unit_if #(
  parameter int OPCODE_W = 4,
  parameter int REG_AW   = 3,
  parameter int ALUF_W   = 2
);
  logic                i_valid;
  logic [OPCODE_W-1:0] i_opcode;
  logic [REG_AW-1:0]   i_rs1;
  logic [REG_AW-1:0]   i_rs2;
  logic [REG_AW-1:0]   i_rd;
  logic                i_zeroE;
  logic [ALUF_W-1:0]   o_aluE;
  logic                o_immE;
  logic                o_memWriteM;
  logic                o_memToRegW;
  logic                o_regWriteW;
  logic [REG_AW-1:0]   o_rdW;
  logic [1:0]          o_fwdA;
  logic [1:0]          o_fwdB;
  logic                o_stallF;
  logic                o_stallD;
  logic                o_flushD;
  logic                o_flushE;
  logic                o_illegal;

  modport master (
    output i_valid, i_opcode, i_rs1, i_rs2, i_rd, i_zeroE,
    input  o_aluE, o_immE, o_memWriteM, o_memToRegW,
    input  o_regWriteW, o_rdW, o_fwdA, o_fwdB,
    input  o_stallF, o_stallD, o_flushD, o_flushE, o_illegal
  );

  modport slave (
    input  i_valid, i_opcode, i_rs1, i_rs2, i_rd, i_zeroE,
    output o_aluE, o_immE, o_memWriteM, o_memToRegW,
    output o_regWriteW, o_rdW, o_fwdA, o_fwdB,
    output o_stallF, o_stallD, o_flushD, o_flushE, o_illegal
  );
endinterface

// File: rtl/pipe_control_unit.sv
// Pipelined opcode decoder: D decode, E/M/W control registers,
// load-use stall, taken-branch flush and E-stage forwarding selects.
module pipe_control_unit #(
  parameter int OPCODE_W = 4,
  parameter int REG_AW   = 3,
  parameter int ALUF_W   = 2
) (
  input logic               i_clk,
  input logic               i_rstn,
  pipe_control_unit_if.slave bus
);

  typedef struct packed {
    logic              branch;
    logic              regWrite;
    logic              memWrite;
    logic              memToReg;
    logic              imm;
    logic              isSw;
    logic              illegal;
    logic [ALUF_W-1:0] alu;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } stage_t;

  stage_t decD;
  stage_t stE;
  stage_t stM;
  stage_t stW;
  logic   usesRs2D;
  logic   loadUse;
  logic   takenE;
  logic   unusedW;

  // Decode the D-stage opcode; invalid slots become NOPs.
  always_comb begin
    decD     = '0;
    usesRs2D = 1'b0;
    decD.rs1 = bus.i_rs1;
    decD.rs2 = bus.i_rs2;
    decD.rd  = bus.i_rd;
    if (bus.i_valid) begin
      case (bus.i_opcode)
        OPCODE_W'(1): begin
          decD.regWrite = 1'b1;
          usesRs2D      = 1'b1;
        end
        OPCODE_W'(2): begin
          decD.regWrite = 1'b1;
          decD.alu      = ALUF_W'(1);
          usesRs2D      = 1'b1;
        end
        OPCODE_W'(3): begin
          decD.regWrite = 1'b1;
          decD.alu      = ALUF_W'(2);
          usesRs2D      = 1'b1;
        end
        OPCODE_W'(4): begin
          decD.regWrite = 1'b1;
          decD.alu      = ALUF_W'(3);
          usesRs2D      = 1'b1;
        end
        OPCODE_W'(5): begin
          decD.regWrite = 1'b1;
          decD.imm      = 1'b1;
        end
        OPCODE_W'(6): begin
          decD.regWrite = 1'b1;
          decD.memToReg = 1'b1;
          decD.imm      = 1'b1;
        end
        OPCODE_W'(7): begin
          decD.memWrite = 1'b1;
          decD.imm      = 1'b1;
          decD.isSw     = 1'b1;
          usesRs2D      = 1'b1;
        end
        OPCODE_W'(8): begin
          decD.branch = 1'b1;
          decD.alu    = ALUF_W'(1);
          usesRs2D    = 1'b1;
        end
        default: decD.illegal = (bus.i_opcode >= OPCODE_W'(9));
      endcase
    end
  end

  // Load in E whose result D needs now; register 0 never hazards.
  assign loadUse = stE.memToReg && (stE.rd != '0) &&
                   ((stE.rd == bus.i_rs1) ||
                    ((stE.rd == bus.i_rs2) && usesRs2D));

  assign takenE = stE.branch && bus.i_zeroE;

  // Advance the control pipe; stall or flush inserts a bubble into E.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stE <= '0;
      stM <= '0;
      stW <= '0;
    end else begin
      stE <= (takenE || loadUse) ? '0 : decD;
      stM <= stE;
      stW <= stM;
    end
  end

  function automatic logic [1:0] fwdSel(
    input logic [REG_AW-1:0] rs,
    input stage_t            m,
    input stage_t            w
  );
    if (m.regWrite && (m.rd != '0) && (m.rd == rs)) return 2'b10;
    if (w.regWrite && (w.rd != '0) && (w.rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  // Operand selects for E; immediate B ignores forwarding except stores.
  always_comb begin
    bus.o_fwdA = fwdSel(stE.rs1, stM, stW);
    bus.o_fwdB = fwdSel(stE.rs2, stM, stW);
    if (stE.imm && !stE.isSw) bus.o_fwdB = 2'b00;
  end

  assign bus.o_flushD    = takenE;
  assign bus.o_flushE    = takenE;
  assign bus.o_stallF    = loadUse && !takenE;
  assign bus.o_stallD    = loadUse && !takenE;
  assign bus.o_aluE      = stE.alu;
  assign bus.o_immE      = stE.imm;
  assign bus.o_illegal   = stE.illegal;
  assign bus.o_memWriteM = stM.memWrite;
  assign bus.o_memToRegW = stW.memToReg;
  assign bus.o_regWriteW = stW.regWrite;
  assign bus.o_rdW       = stW.rd;

  // W-stage fields carried for completeness but not consumed here.
  assign unusedW = ^{stW.branch, stW.memWrite, stW.imm, stW.isSw,
                     stW.illegal, stW.alu, stW.rs1, stW.rs2};

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed bench for pipe_control_unit.
// Inputs change on negedge; outputs sampled 1 ns later.
module tb_pipe_control_unit;

  logic clk;
  logic rstn;
  int   nAsserts;
  int   nFails;

  pipe_control_unit_if bus ();

  pipe_control_unit dut (
    .i_clk (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic allZero(input string tag);
    chk({tag, ".aluE"}, 8'(bus.o_aluE), 8'd0);
    chk({tag, ".immE"}, 8'(bus.o_immE), 8'd0);
    chk({tag, ".memWriteM"}, 8'(bus.o_memWriteM), 8'd0);
    chk({tag, ".memToRegW"}, 8'(bus.o_memToRegW), 8'd0);
    chk({tag, ".regWriteW"}, 8'(bus.o_regWriteW), 8'd0);
    chk({tag, ".rdW"}, 8'(bus.o_rdW), 8'd0);
    chk({tag, ".fwdA"}, 8'(bus.o_fwdA), 8'd0);
    chk({tag, ".fwdB"}, 8'(bus.o_fwdB), 8'd0);
    chk({tag, ".stallF"}, 8'(bus.o_stallF), 8'd0);
    chk({tag, ".stallD"}, 8'(bus.o_stallD), 8'd0);
    chk({tag, ".flushD"}, 8'(bus.o_flushD), 8'd0);
    chk({tag, ".flushE"}, 8'(bus.o_flushE), 8'd0);
    chk({tag, ".illegal"}, 8'(bus.o_illegal), 8'd0);
  endtask

  task automatic cyc(input logic v, input logic [3:0] op,
                     input logic [2:0] r1, input logic [2:0] r2,
                     input logic [2:0] rd, input logic z);
    @(negedge clk);
    bus.i_valid  = v;
    bus.i_opcode = op;
    bus.i_rs1    = r1;
    bus.i_rs2    = r2;
    bus.i_rd     = rd;
    bus.i_zeroE  = z;
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) cyc(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    nAsserts     = 0;
    nFails       = 0;
    rstn         = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_opcode = '0;
    bus.i_rs1    = '0;
    bus.i_rs2    = '0;
    bus.i_rd     = '0;
    bus.i_zeroE  = 1'b0;

    // reset held with ADD driven
    cyc(1, 4'd1, 0, 0, 3, 0);
    cyc(1, 4'd1, 0, 0, 3, 0);
    allZero("rstHeld");
    rstn = 1'b1;
    #1;
    allZero("rstRel");
    cyc(1, 4'd1, 0, 0, 3, 0);
    chk("rstRel.c1.regW", 8'(bus.o_regWriteW), 8'd0);
    cyc(1, 4'd1, 0, 0, 3, 0);
    chk("rstRel.c2.regW", 8'(bus.o_regWriteW), 8'd0);
    cyc(1, 4'd1, 0, 0, 3, 0);
    chk("rstRel.c3.regW", 8'(bus.o_regWriteW), 8'd1);
    chk("rstRel.c3.rdW", 8'(bus.o_rdW), 8'd3);

    // mid-stream reset
    #2 rstn = 1'b0;
    #1;
    allZero("rstMidAsync");
    cyc(1, 4'd1, 0, 0, 3, 0);
    allZero("rstMidHeld");
    rstn = 1'b1;
    #1;
    allZero("rstMidRel");
    cyc(1, 4'd1, 0, 0, 3, 0);
    chk("rstMid.c1.regW", 8'(bus.o_regWriteW), 8'd0);
    cyc(1, 4'd1, 0, 0, 3, 0);
    chk("rstMid.c2.regW", 8'(bus.o_regWriteW), 8'd0);
    cyc(1, 4'd1, 0, 0, 3, 0);
    chk("rstMid.c3.regW", 8'(bus.o_regWriteW), 8'd1);
    nop(4);

    // latency: ADD rd=3, OR rd=5
    cyc(1, 4'd1, 0, 0, 3, 0);
    chk("lat.n.regW", 8'(bus.o_regWriteW), 8'd0);
    cyc(1, 4'd4, 0, 0, 5, 0);
    chk("lat.n1.aluE", 8'(bus.o_aluE), 8'd0);
    chk("lat.n1.regW", 8'(bus.o_regWriteW), 8'd0);
    nop(1);
    chk("lat.n2.aluE", 8'(bus.o_aluE), 8'd3);
    chk("lat.n2.regW", 8'(bus.o_regWriteW), 8'd0);
    nop(1);
    chk("lat.n3.regW", 8'(bus.o_regWriteW), 8'd1);
    chk("lat.n3.rdW", 8'(bus.o_rdW), 8'd3);
    nop(1);
    chk("lat.n4.rdW", 8'(bus.o_rdW), 8'd5);
    nop(1);
    chk("lat.n5.regW", 8'(bus.o_regWriteW), 8'd0);
    nop(2);

    // load-use: LW rd=2; ADD rs1=2
    cyc(1, 4'd6, 0, 0, 2, 0);
    chk("lu.lw.stallF", 8'(bus.o_stallF), 8'd0);
    cyc(1, 4'd1, 2, 0, 4, 0);
    chk("lu.immE", 8'(bus.o_immE), 8'd1);
    chk("lu.stallF", 8'(bus.o_stallF), 8'd1);
    chk("lu.stallD", 8'(bus.o_stallD), 8'd1);
    chk("lu.flushE", 8'(bus.o_flushE), 8'd0);
    cyc(1, 4'd1, 2, 0, 4, 0);
    chk("lu.b.stallF", 8'(bus.o_stallF), 8'd0);
    chk("lu.b.immE", 8'(bus.o_immE), 8'd0);
    chk("lu.b.fwdA", 8'(bus.o_fwdA), 8'd0);
    nop(1);
    chk("lu.fwdA", 8'(bus.o_fwdA), 8'd1);
    chk("lu.memToRegW", 8'(bus.o_memToRegW), 8'd1);
    nop(3);

    // load into r0 never stalls; rs2 of ADDI is not a use
    cyc(1, 4'd6, 0, 0, 0, 0);
    cyc(1, 4'd1, 0, 0, 5, 0);
    chk("lu.r0.stallF", 8'(bus.o_stallF), 8'd0);
    nop(1);
    cyc(1, 4'd6, 0, 0, 3, 0);
    cyc(1, 4'd5, 0, 3, 4, 0);
    chk("lu.immRs2.stallD", 8'(bus.o_stallD), 8'd0);
    nop(3);

    // forward from M on both operands
    cyc(1, 4'd1, 0, 0, 1, 0);
    cyc(1, 4'd2, 1, 1, 6, 0);
    nop(1);
    chk("fwd.M.fwdA", 8'(bus.o_fwdA), 8'd2);
    chk("fwd.M.fwdB", 8'(bus.o_fwdB), 8'd2);
    chk("fwd.M.aluE", 8'(bus.o_aluE), 8'd1);
    nop(3);

    // M wins over W
    cyc(1, 4'd1, 0, 0, 1, 0);
    cyc(1, 4'd1, 0, 0, 1, 0);
    cyc(1, 4'd3, 1, 1, 7, 0);
    nop(1);
    chk("fwd.Mwins.fwdA", 8'(bus.o_fwdA), 8'd2);
    chk("fwd.Mwins.fwdB", 8'(bus.o_fwdB), 8'd2);
    nop(3);

    // writes to r0 never forward
    cyc(1, 4'd1, 0, 0, 0, 0);
    cyc(1, 4'd2, 0, 0, 1, 0);
    nop(1);
    chk("fwd.r0.fwdA", 8'(bus.o_fwdA), 8'd0);
    chk("fwd.r0.fwdB", 8'(bus.o_fwdB), 8'd0);
    nop(3);

    // ADDI masks fwdB; SW keeps store-data forward on B
    cyc(1, 4'd1, 0, 0, 1, 0);
    cyc(1, 4'd5, 1, 1, 2, 0);
    cyc(1, 4'd7, 0, 1, 0, 0);
    chk("fwd.addi.fwdA", 8'(bus.o_fwdA), 8'd2);
    chk("fwd.addi.fwdB", 8'(bus.o_fwdB), 8'd0);
    nop(1);
    chk("fwd.sw.fwdB", 8'(bus.o_fwdB), 8'd1);
    chk("fwd.sw.fwdA", 8'(bus.o_fwdA), 8'd0);
    nop(1);
    chk("fwd.sw.memWriteM", 8'(bus.o_memWriteM), 8'd1);
    nop(3);

    // taken branch
    cyc(1, 4'd8, 0, 0, 0, 0);
    cyc(1, 4'd4, 0, 0, 3, 1);
    chk("br.t.flushD", 8'(bus.o_flushD), 8'd1);
    chk("br.t.flushE", 8'(bus.o_flushE), 8'd1);
    chk("br.t.aluE", 8'(bus.o_aluE), 8'd1);
    nop(1);
    chk("br.t.bubble.aluE", 8'(bus.o_aluE), 8'd0);
    chk("br.t.bubble.flushD", 8'(bus.o_flushD), 8'd0);
    nop(2);
    chk("br.t.regW", 8'(bus.o_regWriteW), 8'd0);
    nop(2);

    // not-taken branch
    cyc(1, 4'd8, 0, 0, 0, 0);
    cyc(1, 4'd4, 0, 0, 3, 0);
    chk("br.nt.flushD", 8'(bus.o_flushD), 8'd0);
    chk("br.nt.flushE", 8'(bus.o_flushE), 8'd0);
    nop(1);
    chk("br.nt.aluE", 8'(bus.o_aluE), 8'd3);
    nop(3);

    // illegal opcode
    cyc(1, 4'hC, 0, 0, 3, 0);
    chk("ill.n.illegal", 8'(bus.o_illegal), 8'd0);
    nop(1);
    chk("ill.n1.illegal", 8'(bus.o_illegal), 8'd1);
    chk("ill.n1.aluE", 8'(bus.o_aluE), 8'd0);
    nop(1);
    chk("ill.n2.illegal", 8'(bus.o_illegal), 8'd0);
    chk("ill.n2.memWriteM", 8'(bus.o_memWriteM), 8'd0);
    nop(1);
    chk("ill.n3.regW", 8'(bus.o_regWriteW), 8'd0);

    // illegal code in an invalid slot is silent
    cyc(0, 4'hC, 0, 0, 3, 0);
    nop(1);
    chk("ill.inv.illegal", 8'(bus.o_illegal), 8'd0);
    nop(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nAsserts, nFails);
    $finish;
  end

endmodule
